router_sync: RTL and testbench

ROUTER_SYNC -- requirements
Module: router_sync

---
 rtl/router_sync.sv | 93 +++++++++
 tb/tb_router_sync.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/router_sync.sv
// Router synchronizer: latches the packet destination, steers FIFO write enables,
// and soft-resets any output FIFO whose valid data sits unread for TIMEOUT cycles.
module router_sync #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  localparam int unsigned NFIFO = 3;
  localparam int unsigned CW    = 6;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]                   addr_q, addr_d;
  logic [NFIFO-1:0][CW-1:0]     cnt_q, cnt_d;
  logic [NFIFO-1:0]             srst_q, srst_d;
  logic [NFIFO-1:0]             vld, rd;

  assign vld = ~{empty_2, empty_1, empty_0};
  assign rd  = {read_enb_2, read_enb_1, read_enb_0};

  assign vld_out_0 = vld[0];
  assign vld_out_1 = vld[1];
  assign vld_out_2 = vld[2];

  assign soft_reset_0 = srst_q[0];
  assign soft_reset_1 = srst_q[1];
  assign soft_reset_2 = srst_q[2];

  // Decode uses the registered address, so a same-cycle header still targets the old FIFO.
  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (addr_q)
      2'b00: begin write_enb = {2'b00, write_enb_reg};       fifo_full = full_0; end
      2'b01: begin write_enb = {1'b0, write_enb_reg, 1'b0};  fifo_full = full_1; end
      2'b10: begin write_enb = {write_enb_reg, 2'b00};       fifo_full = full_2; end
      default: begin write_enb = 3'b000;                     fifo_full = 1'b0;   end
    endcase
  end

  always_comb begin
    addr_d = detect_add ? data_in : addr_q;
  end

  // Per-FIFO idle counters; a read or an empty FIFO clears the count.
  always_comb begin
    cnt_d  = '0;
    srst_d = '0;
    for (int i = 0; i < int'(NFIFO); i++) begin
      if (vld[i] && !rd[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          srst_d[i] = 1'b1;
        end else begin
          cnt_d[i] = CW'(cnt_q[i] + 1'b1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q <= 2'b00;
      cnt_q  <= '0;
      srst_q <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      srst_q <= srst_d;
    end
  end

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: expectations are queued as stimulus is applied
// and popped against the observed outputs.
module tb_router_sync;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       detect_add = 1'b0;
  logic [1:0] data_in = 2'b00;
  logic       write_enb_reg = 1'b0;
  logic       read_enb_0 = 1'b0, read_enb_1 = 1'b0, read_enb_2 = 1'b0;
  logic       empty_0 = 1'b1, empty_1 = 1'b1, empty_2 = 1'b1;
  logic       full_0 = 1'b0, full_1 = 1'b0, full_2 = 1'b0;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  router_sync #(.TIMEOUT(30)) dut (
    .clock(clock), .reset(reset), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
    .full_0(full_0), .full_1(full_1), .full_2(full_2),
    .write_enb(write_enb), .fifo_full(fifo_full),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
  );

  always #5 clock = ~clock;

  task automatic push(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] srst();
    return 32'({soft_reset_2, soft_reset_1, soft_reset_0});
  endfunction

  initial begin
    #1;
    // Reset state and combinational outputs tracking inputs during reset.
    push("rst_soft_reset", 32'h0); check(srst());
    push("rst_write_enb", 32'h0);  check(32'(write_enb));
    push("rst_vld_out", 32'h0);    check(32'({vld_out_2, vld_out_1, vld_out_0}));
    write_enb_reg = 1'b1; #1;
    push("rst_we_track", 32'h1);   check(32'(write_enb));
    write_enb_reg = 1'b0;
    step(); step();
    reset = 1'b0;

    // Address 10 decode and full steering.
    detect_add = 1'b1; data_in = 2'b10; step();
    detect_add = 1'b0; write_enb_reg = 1'b1; full_2 = 1'b1; #1;
    push("dec10_we", 32'h4);       check(32'(write_enb));
    push("dec10_full", 32'h1);     check(32'(fifo_full));
    full_2 = 1'b0; #1;
    push("dec10_full_lo", 32'h0);  check(32'(fifo_full));

    // Invalid address 11 suppresses writes and full.
    write_enb_reg = 1'b0; detect_add = 1'b1; data_in = 2'b11; step();
    detect_add = 1'b0; write_enb_reg = 1'b1; full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1; #1;
    push("dec11_we", 32'h0);       check(32'(write_enb));
    push("dec11_full", 32'h0);     check(32'(fifo_full));
    full_0 = 1'b0; full_2 = 1'b0;

    // Address 01 decode.
    detect_add = 1'b1; data_in = 2'b01; step();
    detect_add = 1'b0; #1;
    push("dec01_we", 32'h2);       check(32'(write_enb));
    push("dec01_full", 32'h1);     check(32'(fifo_full));
    full_1 = 1'b0; write_enb_reg = 1'b0;

    // Same-cycle header and write uses the old address.
    detect_add = 1'b1; data_in = 2'b00; step();
    data_in = 2'b01; write_enb_reg = 1'b1; #1;
    push("same_cyc_old", 32'h1);   check(32'(write_enb));
    step();
    detect_add = 1'b0; #1;
    push("same_cyc_new", 32'h2);   check(32'(write_enb));
    write_enb_reg = 1'b0;

    // Valid flags are inverted empties.
    empty_0 = 1'b0; empty_2 = 1'b0; #1;
    push("vld_pattern", 32'h5);    check(32'({vld_out_2, vld_out_1, vld_out_0}));
    empty_0 = 1'b1; empty_2 = 1'b1;
    step();

    // FIFO 1 timeout, then a repeat after another 30 unread edges.
    empty_1 = 1'b0;
    for (int k = 1; k <= 61; k++) begin
      step();
      push($sformatf("tmo1_edge%0d", k), (k == 30 || k == 60) ? 32'h2 : 32'h0);
      check(srst());
    end
    empty_1 = 1'b1;
    step();

    // FIFO 0 rescued by a read on edge 29.
    empty_0 = 1'b0;
    for (int k = 1; k <= 29; k++) begin
      read_enb_0 = (k == 29);
      step();
      push($sformatf("rescue0_edge%0d", k), 32'h0); check(srst());
    end
    read_enb_0 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      push($sformatf("rescue0_after%0d", k), (k == 30) ? 32'h1 : 32'h0); check(srst());
    end
    empty_0 = 1'b1;
    step();

    // FIFO 2 reset mid-count restarts the full timeout.
    empty_2 = 1'b0;
    for (int k = 1; k <= 20; k++) step();
    push("mid_pre_reset", 32'h0);  check(srst());
    #2 reset = 1'b1; write_enb_reg = 1'b1; #1;
    push("mid_reset_srst", 32'h0); check(srst());
    push("mid_reset_addr", 32'h1); check(32'(write_enb));
    write_enb_reg = 1'b0;
    step(); step();
    reset = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      push($sformatf("mid_after%0d", k), (k == 30) ? 32'h4 : 32'h0); check(srst());
    end
    empty_2 = 1'b1;
    step();

    // Simultaneous timeouts on FIFOs 0 and 1.
    empty_0 = 1'b0; empty_1 = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      step();
      push($sformatf("simul_edge%0d", k), (k == 30) ? 32'h3 : 32'h0); check(srst());
    end
    empty_0 = 1'b1; empty_1 = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
